wasm_stack_core: RTL and testbench
==================================

Name: wasm_stack_core

Overview:
- Minimal WebAssembly stack-machine core. It executes a straight-line bytecode function from a byte-addressed ROM (genrom) starting at address 0.
- It exposes the top-of-stack value and a trap/status code.
- It sits between the instruction ROM and the system/testbench and has no data memory.

Parameters:
- MEM_DEPTH, 4, ROM address width minus one; mem_addr is MEM_DEPTH+1 bits.
- STACK_DEPTH, 16, number of 64-bit operand-stack entries.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- result  output  64  current top-of-stack value; 0 when stack empty.
- result_empty  output  1  1 when operand stack is empty.
- trap  output  4  status code (see Behaviour).
- mem_addr  output  MEM_DEPTH+1  ROM byte address (= PC).
- mem_extra  output  4  number of extra bytes requested beyond the first; ROM returns 1+mem_extra bytes.
- mem_data  input  128  ROM data, little-endian: byte at mem_addr in [7:0], mem_addr+1 in [15:8], etc.
- mem_error  input  1  ROM access out of bounds; valid with mem_data.

Behaviour:
- Reset (reset=0, async): PC=0, stack empty, state FETCH, result=0, result_empty=1, trap=0, mem_addr=0, mem_extra=4'hF.
- ROM is synchronous: mem_data/mem_error are valid one cycle after mem_addr. The core always requests 16 bytes (mem_extra=15).
- FSM FETCH -> EXEC -> FETCH, giving 2 cycles per instruction.
  - FETCH: drive mem_addr=PC.
  - EXEC: decode mem_data[7:0], update stack, PC += instruction length.
- When trap≠0, the FSM enters HALT and holds all state until reset.
- Trap codes:
  - 0 running
  - 1 ENDED (end, 0x0B)
  - 2 UNREACHABLE (0x00)
  - 3 INVALID_OPCODE (also malformed LEB)
  - 4 STACK_UNDERFLOW
  - 5 STACK_OVERFLOW
  - 6 MEM_ERROR (mem_error=1 in EXEC; takes priority over decode)
- Opcodes:
  - 0x01 nop.
  - 0x1A drop.
  - 0x41 i32.const: signed LEB128, ≤5 bytes.
  - 0x42 i64.const: signed LEB128, ≤10 bytes.
  - i32 compares 0x45 eqz, 0x46–0x4F (eq, ne, lt_s, lt_u, gt_s, gt_u, le_s, le_u, ge_s, ge_u).
  - i64 compares 0x50 eqz, 0x51–0x5A (same order).
  - 0x6A/0x6B i32.add/sub; 0x7C/0x7D i64.add/sub.
- Width rules:
  - i32 ops use operand bits [31:0]; i32 results are zero-extended to 64 bits.
  - Comparison results are i32 0/1.
  - Add/sub wrap modulo 2^N.
  - Binary ops: second-from-top is lhs, top is rhs; both are popped and the result pushed.
- LEB decode: 7 bits per byte, continuation in bit 7, sign-extended from bit 6 of the final byte.
  - Continuation set on byte 5 (i32) or byte 10 (i64) gives trap 3.
  - i32.const value is truncated to 32 bits and zero-extended.
  - Instruction length = 1 + LEB byte count.
- Stack errors:
  - Push with stack full gives trap 5.
  - Popping more operands than present gives trap 4.
  - On either trap the stack is left unchanged.
- Output timing: result and result_empty reflect stack state registered at the end of EXEC. trap updates in the same cycle.
- PC wrap at 2^(MEM_DEPTH+1) is modulo.

Decomposition:
- Package wasm_pkg holds:
  - opcode localparams;
  - trap code enum (4-bit);
  - FSM state enum (FETCH, EXEC, HALT);
  - default STACK_DEPTH.
- One sub-module, leb128_decoder: combinational.
  - Inputs: 80-bit byte window and an is64 flag.
  - Outputs: 64-bit value, 4-bit byte count, malformed flag.

Test Plan:
- i64.ne 0 vs 1: ROM 42 00 42 01 52 0B, release reset. Within 12 cycles, required: result=1, result_empty=0, trap=1.
- i64.eq of equal values: ROM 42 05 42 05 51 0B. Required: result=1. Also ROM 42 05 42 06 51 0B, required: result=0.
- LEB sign and width:
  - ROM 41 7F 0B: result=64'h00000000FFFFFFFF.
  - ROM 42 7F 0B: result=64'hFFFFFFFFFFFFFFFF.
  - ROM 42 80 01 0B: result=128.
- Underflow: ROM 1A 0B: trap=4, result_empty=1, PC frozen; trap persists until reset.
- Invalid opcode and unreachable:
  - ROM FF: trap=3.
  - ROM 00: trap=2.
  - ROM 41 80 80 80 80 80 0B: trap=3.
- Reset mid-run: assert reset during the second instruction. Outputs immediately go to result=0, result_empty=1, trap=0. On release, the program re-executes from address 0 and gives identical results.

Source files
------------

// File: rtl/wasm_pkg.sv
// Shared opcode, trap and FSM definitions for the minimal WebAssembly stack core.
package wasm_pkg;

  localparam int STACK_DEPTH_DEFAULT = 16;

  localparam logic [7:0] OP_UNREACHABLE = 8'h00;
  localparam logic [7:0] OP_NOP         = 8'h01;
  localparam logic [7:0] OP_END         = 8'h0B;
  localparam logic [7:0] OP_DROP        = 8'h1A;
  localparam logic [7:0] OP_I32_CONST   = 8'h41;
  localparam logic [7:0] OP_I64_CONST   = 8'h42;
  localparam logic [7:0] OP_I32_EQZ     = 8'h45;
  localparam logic [7:0] OP_I32_EQ      = 8'h46;
  localparam logic [7:0] OP_I32_GE_U    = 8'h4F;
  localparam logic [7:0] OP_I64_EQZ     = 8'h50;
  localparam logic [7:0] OP_I64_EQ      = 8'h51;
  localparam logic [7:0] OP_I64_GE_U    = 8'h5A;
  localparam logic [7:0] OP_I32_ADD     = 8'h6A;
  localparam logic [7:0] OP_I32_SUB     = 8'h6B;
  localparam logic [7:0] OP_I64_ADD     = 8'h7C;
  localparam logic [7:0] OP_I64_SUB     = 8'h7D;

  typedef enum logic [3:0] {
    TRAP_NONE        = 4'd0,
    TRAP_ENDED       = 4'd1,
    TRAP_UNREACHABLE = 4'd2,
    TRAP_INVALID     = 4'd3,
    TRAP_UNDERFLOW   = 4'd4,
    TRAP_OVERFLOW    = 4'd5,
    TRAP_MEM_ERROR   = 4'd6
  } trap_t;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/leb128_decoder.sv
// Combinational signed LEB128 decoder for the i32/i64 const immediates.
module leb128_decoder (
  input  logic [79:0] window,
  input  logic        is64,
  output logic [63:0] value,
  output logic [3:0]  count,
  output logic        malformed
);

  logic [63:0] acc;
  logic        done;
  logic [3:0]  max_bytes;

  always_comb begin
    acc       = '0;
    done      = 1'b0;
    count     = 4'd0;
    max_bytes = is64 ? 4'd10 : 4'd5;
    for (int i = 0; i < 10; i++) begin
      if (!done && (4'(i) < max_bytes)) begin
        acc = acc | ({57'd0, window[8*i +: 7]} << (7*i));
        if (!window[8*i+7]) begin
          done  = 1'b1;
          count = 4'(i + 1);
          // Sign extension only matters while the payload is shorter than 64 bits.
          if (window[8*i+6] && (i < 9))
            acc = acc | (~64'd0 << (7*(i+1)));
        end
      end
    end
    malformed = !done;
    value     = is64 ? acc : {32'd0, acc[31:0]};
  end

endmodule

// File: rtl/wasm_stack_core.sv
// Two-cycle-per-instruction WebAssembly stack machine executing straight-line bytecode from ROM.
module wasm_stack_core
  import wasm_pkg::*;
#(
  parameter int MEM_DEPTH   = 4,
  parameter int STACK_DEPTH = STACK_DEPTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [63:0]          result,
  output logic                 result_empty,
  output logic [3:0]           trap,
  output logic [MEM_DEPTH:0]   mem_addr,
  output logic [3:0]           mem_extra,
  input  logic [127:0]         mem_data,
  input  logic                 mem_error
);

  localparam int SPW = $clog2(STACK_DEPTH);

  state_t               state;
  trap_t                trap_q, exec_trap;
  logic [MEM_DEPTH:0]   pc;
  logic [SPW:0]         sp;
  logic [63:0]          stk [STACK_DEPTH];

  logic [SPW-1:0]       top_idx, nos_idx, wr_idx;
  logic [SPW+1:0]       sp_ext, pop_ext, depth_after;
  logic [7:0]           op;
  logic [1:0]           pops;
  logic                 push;
  logic [63:0]          push_val, lhs, rhs;
  logic [3:0]           len, sel32, sel64;
  logic [63:0]          leb_value;
  logic [3:0]           leb_count;
  logic                 leb_bad;
  logic signed [63:0]   lhs32_s, rhs32_s, lhs64_s, rhs64_s;
  logic [63:0]          lhs32_u, rhs32_u;
  logic                 unused_bits;

  // Relational ops indexed as offsets from the eqz opcode of each width.
  function automatic logic cmp_rel(input logic [3:0] sel,
                                   input logic signed [63:0] a_s, input logic signed [63:0] b_s,
                                   input logic [63:0] a_u, input logic [63:0] b_u);
    case (sel)
      4'd1:    return a_u == b_u;
      4'd2:    return a_u != b_u;
      4'd3:    return a_s <  b_s;
      4'd4:    return a_u <  b_u;
      4'd5:    return a_s >  b_s;
      4'd6:    return a_u >  b_u;
      4'd7:    return a_s <= b_s;
      4'd8:    return a_u <= b_u;
      4'd9:    return a_s >= b_s;
      4'd10:   return a_u >= b_u;
      default: return 1'b0;
    endcase
  endfunction

  assign op          = mem_data[7:0];
  assign unused_bits = ^mem_data[127:88];
  assign mem_addr    = pc;
  assign mem_extra   = 4'hF;
  assign trap        = trap_q;

  assign top_idx = SPW'(sp - (SPW+1)'(1));
  assign nos_idx = SPW'(sp - (SPW+1)'(2));
  assign rhs     = stk[top_idx];
  assign lhs     = stk[nos_idx];

  assign result_empty = (sp == '0);
  assign result       = result_empty ? 64'd0 : rhs;

  assign lhs32_s = {{32{lhs[31]}}, lhs[31:0]};
  assign rhs32_s = {{32{rhs[31]}}, rhs[31:0]};
  assign lhs32_u = {32'd0, lhs[31:0]};
  assign rhs32_u = {32'd0, rhs[31:0]};
  assign lhs64_s = signed'(lhs);
  assign rhs64_s = signed'(rhs);
  assign sel32   = 4'(op - OP_I32_EQZ);
  assign sel64   = 4'(op - OP_I64_EQZ);

  leb128_decoder u_leb (
    .window    (mem_data[87:8]),
    .is64      (op == OP_I64_CONST),
    .value     (leb_value),
    .count     (leb_count),
    .malformed (leb_bad)
  );

  always_comb begin
    pops      = 2'd0;
    push      = 1'b0;
    push_val  = '0;
    len       = 4'd1;
    exec_trap = TRAP_NONE;
    if (op == OP_NOP) begin
      pops = 2'd0;
    end else if (op == OP_DROP) begin
      pops = 2'd1;
    end else if (op == OP_END) begin
      exec_trap = TRAP_ENDED;
    end else if (op == OP_UNREACHABLE) begin
      exec_trap = TRAP_UNREACHABLE;
    end else if (op == OP_I32_CONST || op == OP_I64_CONST) begin
      push     = 1'b1;
      push_val = leb_value;
      len      = 4'd1 + leb_count;
      if (leb_bad) exec_trap = TRAP_INVALID;
    end else if (op == OP_I32_EQZ) begin
      pops = 2'd1; push = 1'b1; push_val = {63'd0, rhs[31:0] == 32'd0};
    end else if (op == OP_I64_EQZ) begin
      pops = 2'd1; push = 1'b1; push_val = {63'd0, rhs == 64'd0};
    end else if (op >= OP_I32_EQ && op <= OP_I32_GE_U) begin
      pops = 2'd2; push = 1'b1;
      push_val = {63'd0, cmp_rel(sel32, lhs32_s, rhs32_s, lhs32_u, rhs32_u)};
    end else if (op >= OP_I64_EQ && op <= OP_I64_GE_U) begin
      pops = 2'd2; push = 1'b1;
      push_val = {63'd0, cmp_rel(sel64, lhs64_s, rhs64_s, lhs, rhs)};
    end else if (op == OP_I32_ADD) begin
      pops = 2'd2; push = 1'b1; push_val = {32'd0, lhs[31:0] + rhs[31:0]};
    end else if (op == OP_I32_SUB) begin
      pops = 2'd2; push = 1'b1; push_val = {32'd0, lhs[31:0] - rhs[31:0]};
    end else if (op == OP_I64_ADD) begin
      pops = 2'd2; push = 1'b1; push_val = lhs + rhs;
    end else if (op == OP_I64_SUB) begin
      pops = 2'd2; push = 1'b1; push_val = lhs - rhs;
    end else begin
      exec_trap = TRAP_INVALID;
    end

    sp_ext      = (SPW+2)'(sp);
    pop_ext     = (SPW+2)'(pops);
    depth_after = sp_ext - pop_ext + (SPW+2)'(push);
    if (exec_trap == TRAP_NONE) begin
      if (pop_ext > sp_ext)
        exec_trap = TRAP_UNDERFLOW;
      else if (depth_after > (SPW+2)'(STACK_DEPTH))
        exec_trap = TRAP_OVERFLOW;
    end
    // A failed ROM read makes the fetched byte meaningless, so it overrides any decode outcome.
    if (mem_error) exec_trap = TRAP_MEM_ERROR;
  end

  assign wr_idx = SPW'(sp_ext - pop_ext);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_FETCH;
      pc     <= '0;
      sp     <= '0;
      trap_q <= TRAP_NONE;
    end else begin
      case (state)
        ST_FETCH: state <= ST_EXEC;
        ST_EXEC: begin
          if (exec_trap != TRAP_NONE) begin
            trap_q <= exec_trap;
            state  <= ST_HALT;
          end else begin
            pc    <= pc + (MEM_DEPTH+1)'(len);
            sp    <= depth_after[SPW:0];
            state <= ST_FETCH;
          end
        end
        default: state <= ST_HALT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_EXEC && exec_trap == TRAP_NONE && push)
      stk[wr_idx] <= push_val;
  end

endmodule

// File: tb/tb_wasm_stack_core.sv
// Directed programs with a scoreboard checked whenever the core halts on a trap.
module tb_wasm_stack_core;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [63:0]  result;
  logic         result_empty;
  logic [3:0]   trap;
  logic [4:0]   mem_addr;
  logic [3:0]   mem_extra;
  logic [127:0] mem_data = '0;
  logic         mem_error = 1'b0;
  logic         err_inject = 1'b0;
  logic [7:0]   rom [32];

  typedef struct {
    string       name;
    logic [63:0] res;
    logic        empty;
    logic [3:0]  trap;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  wasm_stack_core #(.MEM_DEPTH(4), .STACK_DEPTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .result       (result),
    .result_empty (result_empty),
    .trap         (trap),
    .mem_addr     (mem_addr),
    .mem_extra    (mem_extra),
    .mem_data     (mem_data),
    .mem_error    (mem_error)
  );

  // Synchronous ROM: 16 bytes starting at mem_addr, wrapping over the 32-byte space.
  always @(posedge clk) begin
    for (int i = 0; i < 16; i++)
      mem_data[8*i +: 8] <= rom[(int'(mem_addr) + i) % 32];
    mem_error <= err_inject;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: the first cycle trap becomes nonzero is the core's output event.
  initial begin
    logic seen;
    exp_t e;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset || trap == 4'd0) begin
        seen = 1'b0;
      end else if (!seen) begin
        seen = 1'b1;
        done_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_halt", {60'd0, trap}, 64'd0);
        end else begin
          e = sb.pop_front();
          check({e.name, ".result"}, result, e.res);
          check({e.name, ".empty"}, {63'd0, result_empty}, {63'd0, e.empty});
          check({e.name, ".trap"}, {60'd0, trap}, {60'd0, e.trap});
        end
      end
    end
  end

  task automatic load(input logic [95:0] p, input int n);
    for (int i = 0; i < 32; i++)
      rom[i] = (i < n) ? p[8*(n-1-i) +: 8] : 8'h00;
  endtask

  task automatic expect_halt(input string name, input logic [63:0] r, input logic e,
                             input logic [3:0] t, input int budget);
    exp_t x;
    int start;
    x.name = name; x.res = r; x.empty = e; x.trap = t;
    sb.push_back(x);
    start = done_cnt;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < budget && done_cnt == start; c++) @(negedge clk);
    #1;
    check({name, ".halted"}, {63'd0, done_cnt != start}, 64'd1);
    if (done_cnt == start) sb.delete();
  endtask

  task automatic run(input string name, input logic [95:0] p, input int n,
                     input logic [63:0] r, input logic e, input logic [3:0] t);
    reset = 1'b0;
    load(p, n);
    expect_halt(name, r, e, t, 60);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("reset.result", result, 64'd0);
    check("reset.empty", {63'd0, result_empty}, 64'd1);
    check("reset.trap", {60'd0, trap}, 64'd0);
    check("reset.mem_addr", {59'd0, mem_addr}, 64'd0);
    check("reset.mem_extra", {60'd0, mem_extra}, 64'hF);

    run("i64_ne",     96'h42_00_42_01_52_0B, 6, 64'd1, 1'b0, 4'd1);
    run("i64_eq_t",   96'h42_05_42_05_51_0B, 6, 64'd1, 1'b0, 4'd1);
    run("i64_eq_f",   96'h42_05_42_06_51_0B, 6, 64'd0, 1'b0, 4'd1);
    run("i32_m1",     96'h41_7F_0B, 3, 64'h00000000FFFFFFFF, 1'b0, 4'd1);
    run("i64_m1",     96'h42_7F_0B, 3, 64'hFFFFFFFFFFFFFFFF, 1'b0, 4'd1);
    run("i64_128",    96'h42_80_01_0B, 4, 64'd128, 1'b0, 4'd1);
    run("i32_add",    96'h41_7F_41_01_6A_0B, 6, 64'd0, 1'b0, 4'd1);
    run("i64_sub",    96'h42_00_42_01_7D_0B, 6, 64'hFFFFFFFFFFFFFFFF, 1'b0, 4'd1);
    run("i32_lt_s",   96'h41_7F_41_00_48_0B, 6, 64'd1, 1'b0, 4'd1);
    run("i32_lt_u",   96'h41_7F_41_00_49_0B, 6, 64'd0, 1'b0, 4'd1);
    run("i64_gt_u",   96'h42_7F_42_01_56_0B, 6, 64'd1, 1'b0, 4'd1);
    run("i32_eqz_lo", 96'h42_80_80_80_80_10_45_0B, 8, 64'd1, 1'b0, 4'd1);
    run("add_uflow",  96'h41_01_6A, 3, 64'd1, 1'b0, 4'd4);
    run("invalid",    96'hFF, 1, 64'd0, 1'b1, 4'd3);
    run("unreach",    96'h00, 1, 64'd0, 1'b1, 4'd2);
    run("leb_bad",    96'h41_80_80_80_80_80_0B, 7, 64'd0, 1'b1, 4'd3);

    // Underflow: PC stays on the faulting drop and the trap holds.
    load(96'h1A_0B, 2);
    expect_halt("drop_uflow", 64'd0, 1'b1, 4'd4, 40);
    repeat (5) @(negedge clk);
    check("uflow.hold_trap", {60'd0, trap}, 64'd4);
    check("uflow.pc_frozen", {59'd0, mem_addr}, 64'd0);
    reset = 1'b0;

    // Sixteen pushes fill the whole ROM; PC wraps and the seventeenth overflows.
    for (int i = 0; i < 32; i++) rom[i] = (i % 2 == 0) ? 8'h41 : 8'h00;
    expect_halt("overflow", 64'd0, 1'b0, 4'd5, 100);
    check("overflow.pc_wrap", {59'd0, mem_addr}, 64'd0);
    reset = 1'b0;

    load(96'h01_0B, 2);
    err_inject = 1'b1;
    expect_halt("mem_err", 64'd0, 1'b1, 4'd6, 40);
    reset = 1'b0;
    err_inject = 1'b0;

    // Reset asserted asynchronously while the second instruction executes.
    load(96'h42_00_42_01_52_0B, 6);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst.result", result, 64'd0);
    check("midrst.empty", {63'd0, result_empty}, 64'd1);
    check("midrst.trap", {60'd0, trap}, 64'd0);
    check("midrst.mem_addr", {59'd0, mem_addr}, 64'd0);
    expect_halt("rerun", 64'd1, 1'b0, 4'd1, 40);
    reset = 1'b0;

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
